tx_frame_scheduler: RTL
=======================

// Module: tx_frame_scheduler
// PURPOSE
//  Frame-level controller for the serial transmit path in front of the bit stuffer.
//  Arbitrates two byte-stream requesters (round-robin, one whole frame per grant).
//  Wraps each frame in 8'h7E flags and serialises LSB-first at one bit per baud period.
//  Drives the stuffer's txin/enable; flag_active tells the downstream mux to bypass stuffing.
// PARAMETERS
//  GAP_BITS    2      idle-high bit periods inserted between frames (>=1)
//  FLAG_BYTE   8'h7E  opening/closing flag pattern
//  ABORT_BYTE  8'hFF  pattern sent on requester underrun
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  baudrate     in   8  clocks per bit; value 0 treated as 1
//  req_valid    in   2  [i]: requester i has a byte on req_data[i]
//  req_data     in   2x8 byte from each requester
//  req_last     in   2  [i]: current byte is the last of the frame
//  req_ready    out  2  [i]: one-cycle pulse, byte from requester i accepted
//  grant        out  2  one-hot owner of current frame; 0 when idle
//  txin         out  1  serial bit to stuffer (idle level 1)
//  tx_enable    out  1  stuffer enable; high from first flag bit to end of closing flag
//  flag_active  out  1  current bit belongs to a flag/abort byte (stuffing bypassed)
//  busy         out  1  state != IDLE
//  underrun     out  1  one-cycle pulse when a frame is aborted
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, req_ready=0, txin=1, tx_enable=0, flag_active=0,
//   busy=0, underrun=0, rr pointer=0 (requester 0 preferred), baud counter=1.
//  Baud tick: counter 1..max(baudrate,1); bit_tick when counter==limit, then reload 1.
//   Counter runs only while busy; held at 1 in IDLE so first bit is a full period.
//   baudrate change takes effect at next reload.
//  States: IDLE -> OPEN_FLAG -> DATA -> CLOSE_FLAG -> GAP -> IDLE; DATA -> ABORT -> GAP.
//  IDLE: if any req_valid, grant = rr-preferred valid requester else the other;
//   same cycle: load FLAG_BYTE into shifter, bit index=0, go OPEN_FLAG.
//  Grant held constant until return to IDLE; rr pointer flips to other requester at grant.
//  OPEN_FLAG: 8 bits, flag_active=1; on 8th bit_tick: if granted req_valid, load
//   req_data, pulse req_ready, latch req_last, go DATA; else go ABORT.
//  DATA: 8 bits, flag_active=0; on 8th bit_tick: latched last -> load FLAG_BYTE,
//   CLOSE_FLAG; else if req_valid -> load next byte, pulse req_ready; else ABORT.
//  ABORT: load ABORT_BYTE, pulse underrun on entry, 8 bits with flag_active=1, then GAP.
//  CLOSE_FLAG: 8 bits flag_active=1, then GAP. GAP: txin=1, tx_enable=0,
//   GAP_BITS bit_ticks, then IDLE (grant cleared on entry to IDLE).
//  txin = shifter[0] registered; shifter shifts right on every bit_tick.
//  req_ready never pulses to a non-granted requester; at most one pulse per byte.
//  Latency: req_valid in IDLE -> tx_enable high next cycle; byte accepted exactly at
//   the bit_tick ending the previous byte, so no gap bits inside a frame.
//  Simultaneous valid from both in IDLE: rr pointer decides; single valid always wins.
//  req_valid dropping mid-byte is ignored; only sampled at byte boundaries.
//  Reset mid-frame: returns to reset values next cycle; partial frame discarded,
//   no underrun pulse.
// STRUCTURE
//  Package tx_sched_pkg: state_t enum (IDLE, OPEN_FLAG, DATA, ABORT, CLOSE_FLAG, GAP),
//   FLAG_BYTE/ABORT_BYTE defaults, BIT_CNT_W=3.
//  Sub-module baud_tick_gen (clk, reset, run, baudrate -> bit_tick); FSM, shifter,
//   round-robin pointer live in this module.
// TESTING
//  baudrate=4, req0 sends {8'hA5 last} -> txin 7E,A5,7E LSB-first, 4 clk/bit, 1 ready pulse.
//  Both valid in IDLE after reset -> grant=01 first frame, grant=10 next frame (rr).
//  3-byte frame 11,22,33 -> 3 ready pulses, each at final tick of prior byte, no idle bits.
//  req0 drops valid after byte 1 (not last) -> ABORT FF sent, underrun=1 one cycle, GAP, IDLE.
//  baudrate=0 -> behaves as 1 clk/bit; baudrate changed 4->8 mid-frame -> new rate next bit.
//  Assert reset during DATA -> next cycle txin=1, tx_enable=0, grant=0; new frame starts clean.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit frame scheduler.
//  state_t      : frame FSM states
//  *_DEF        : default flag/abort patterns and inter-frame gap length
//  BIT_CNT_W    : width of the bit-within-byte index
package tx_sched_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned BAUD_W       = 8;
   localparam int unsigned BIT_CNT_W    = 3;
   localparam int unsigned GAP_BITS_DEF = 2;

   localparam logic [BYTE_W-1:0] FLAG_BYTE_DEF  = 8'h7E;
   localparam logic [BYTE_W-1:0] ABORT_BYTE_DEF = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      OPEN_FLAG,
      DATA,
      ABORT,
      CLOSE_FLAG,
      GAP
   } state_t;

   // States in which a byte is being shifted onto the line.
   function automatic logic sends_byte(input state_t s);
      return (s == OPEN_FLAG) || (s == DATA) || (s == ABORT) || (s == CLOSE_FLAG);
   endfunction

   // States whose byte bypasses the bit stuffer.
   function automatic logic is_flag_byte(input state_t s);
      return (s == OPEN_FLAG) || (s == ABORT) || (s == CLOSE_FLAG);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period tick generator.
//  clk, reset : system clock, synchronous active-high reset
//  run        : count while high; held at 1 otherwise so the first bit is a full period
//  baudrate   : clocks per bit (0 treated as 1), sampled at each reload
//  bit_tick   : high on the last clock of each bit period (combinational)
module baud_tick_gen
   import tx_sched_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [BAUD_W-1:0] baudrate,
   output logic              bit_tick
);

   logic [BAUD_W-1:0] cnt_q, cnt_d;
   logic [BAUD_W-1:0] limit_q, limit_d;
   logic [BAUD_W-1:0] limit_eff;

   assign limit_eff = (baudrate == '0) ? BAUD_W'(1) : baudrate;

   // Limit is latched at reload so a rate change never truncates the current bit.
   assign bit_tick = run && (cnt_q == limit_q);

   always_comb begin
      cnt_d   = cnt_q;
      limit_d = limit_q;
      if (!run || bit_tick) begin
         cnt_d   = BAUD_W'(1);
         limit_d = limit_eff;
      end else begin
         cnt_d = cnt_q + BAUD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= BAUD_W'(1);
         limit_q <= BAUD_W'(1);
      end else begin
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frame-level transmit controller: round-robin arbitration of two byte requesters,
// flag framing, abort on underrun and LSB-first serialisation towards the bit stuffer.
//  clk, reset   : system clock, synchronous active-high reset
//  baudrate     : clocks per bit (0 treated as 1)
//  req_valid/req_data/req_last : per-requester byte stream
//  req_ready    : one-cycle accept pulse to the granted requester
//  grant        : one-hot frame owner, 0 when idle
//  txin         : serial bit (idle 1);  tx_enable : stuffer enable during flag/data/abort bytes
//  flag_active  : current bit is part of a flag/abort byte
//  busy         : not idle;  underrun : one-cycle pulse on frame abort
module tx_frame_scheduler
   import tx_sched_pkg::*;
#(
   parameter int unsigned       GAP_BITS   = GAP_BITS_DEF,
   parameter logic [BYTE_W-1:0] FLAG_BYTE  = FLAG_BYTE_DEF,
   parameter logic [BYTE_W-1:0] ABORT_BYTE = ABORT_BYTE_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BAUD_W-1:0]      baudrate,
   input  logic [1:0]             req_valid,
   input  logic [1:0][BYTE_W-1:0] req_data,
   input  logic [1:0]             req_last,
   output logic [1:0]             req_ready,
   output logic [1:0]             grant,
   output logic                   txin,
   output logic                   tx_enable,
   output logic                   flag_active,
   output logic                   busy,
   output logic                   underrun
);

   localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   state_t                 state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic                   rr_q, rr_d;
   logic [BYTE_W-1:0]      shifter_q, shifter_d;
   logic [BIT_CNT_W-1:0]   bit_idx_q, bit_idx_d;
   logic                   last_q, last_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [1:0]             req_ready_q, req_ready_d;
   logic                   txin_q, txin_d;
   logic                   tx_enable_q, tx_enable_d;
   logic                   flag_active_q, flag_active_d;
   logic                   busy_q, busy_d;
   logic                   underrun_q, underrun_d;

   logic                   bit_tick;
   logic                   byte_end;
   logic                   gidx;
   logic                   pick;

   baud_tick_gen u_baud (
      .clk      (clk),
      .reset    (reset),
      .run      (busy_q),
      .baudrate (baudrate),
      .bit_tick (bit_tick)
   );

   assign gidx     = grant_q[1];
   assign byte_end = bit_tick && (bit_idx_q == BIT_CNT_W'(BYTE_W - 1));

   // Next-state, shifter and output decode.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      shifter_d   = shifter_q;
      bit_idx_d   = bit_idx_q;
      last_d      = last_q;
      gap_cnt_d   = gap_cnt_q;
      req_ready_d = '0;
      underrun_d  = 1'b0;
      pick        = 1'b0;

      if (bit_tick && sends_byte(state_q)) begin
         shifter_d = shifter_q >> 1;
         bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               pick      = req_valid[rr_q] ? rr_q : ~rr_q;
               grant_d   = pick ? 2'b10 : 2'b01;
               rr_d      = ~pick;
               shifter_d = FLAG_BYTE;
               bit_idx_d = '0;
               state_d   = OPEN_FLAG;
            end
         end
         OPEN_FLAG, DATA: begin
            // Next byte is taken exactly on the tick that ends the current one.
            if (byte_end) begin
               if ((state_q == DATA) && last_q) begin
                  shifter_d = FLAG_BYTE;
                  state_d   = CLOSE_FLAG;
               end else if (req_valid[gidx]) begin
                  shifter_d         = req_data[gidx];
                  req_ready_d[gidx] = 1'b1;
                  last_d            = req_last[gidx];
                  state_d           = DATA;
               end else begin
                  shifter_d  = ABORT_BYTE;
                  underrun_d = 1'b1;
                  state_d    = ABORT;
               end
            end
         end
         ABORT, CLOSE_FLAG: begin
            if (byte_end) begin
               gap_cnt_d = '0;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (bit_tick) begin
               if (gap_cnt_q == GAP_W'(GAP_BITS - 1)) begin
                  grant_d = '0;
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line outputs follow the next state so txin tracks the shifter without lag.
      tx_enable_d   = sends_byte(state_d);
      txin_d        = tx_enable_d ? shifter_d[0] : 1'b1;
      flag_active_d = is_flag_byte(state_d);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         rr_q          <= 1'b0;
         shifter_q     <= '1;
         bit_idx_q     <= '0;
         last_q        <= 1'b0;
         gap_cnt_q     <= '0;
         req_ready_q   <= '0;
         txin_q        <= 1'b1;
         tx_enable_q   <= 1'b0;
         flag_active_q <= 1'b0;
         busy_q        <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_q          <= rr_d;
         shifter_q     <= shifter_d;
         bit_idx_q     <= bit_idx_d;
         last_q        <= last_d;
         gap_cnt_q     <= gap_cnt_d;
         req_ready_q   <= req_ready_d;
         txin_q        <= txin_d;
         tx_enable_q   <= tx_enable_d;
         flag_active_q <= flag_active_d;
         busy_q        <= busy_d;
         underrun_q    <= underrun_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign grant       = grant_q;
   assign txin        = txin_q;
   assign tx_enable   = tx_enable_q;
   assign flag_active = flag_active_q;
   assign busy        = busy_q;
   assign underrun    = underrun_q;

endmodule
